// File: rtl/d_cs_chunk_sequencer.sv
// Chien-search chunk sequencer: accepts one packed ELP bundle,
// runs the CS engine per chunk and reports per-chunk results.
module d_cs_chunk_sequencer #(
  parameter int Multi             = 2,
  parameter int GaloisFieldDegree = 12,
  parameter int MaxErrorCountBits = 9,
  parameter int ELPCoefficients   = 15,
  parameter int ChunkBits         = 1,
  parameter int TimeoutCycles     = 4096,
  parameter int TimeoutBits       = 13
) (
  input  logic                     i_clk,
  input  logic                     i_RESET,
  input  logic                     i_stop_dec,
  input  logic                     i_exe_cs,
  input  logic [Multi-1:0]         i_kes_sequence_end,
  input  logic [Multi-1:0]         i_kes_fail,
  input  logic [Multi*MaxErrorCountBits-1:0] i_error_count,
  input  logic [Multi*GaloisFieldDegree*ELPCoefficients-1:0] i_ELP_coef,
  output logic                     o_cs_available,
  output logic                     o_cs_start,
  output logic [GaloisFieldDegree*ELPCoefficients-1:0] o_cs_coef,
  output logic [ChunkBits-1:0]     o_cs_chunk_number,
  input  logic                     i_cs_done,
  input  logic [MaxErrorCountBits-1:0] i_root_count,
  output logic                     o_result_valid,
  output logic [ChunkBits-1:0]     o_result_chunk_number,
  output logic                     o_result_fail,
  output logic [MaxErrorCountBits-1:0] o_result_error_count,
  output logic                     o_sequence_done
);

  localparam int GFD = GaloisFieldDegree;
  localparam int MEB = MaxErrorCountBits;
  localparam int ELP = ELPCoefficients;
  localparam int CW  = GFD * ELP;
  localparam int BW  = Multi * CW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_START,
    S_WAIT,
    S_REPORT,
    S_DONE
  } state_t;

  state_t state, state_n;

  logic [Multi-1:0]       seq_end_q;
  logic [Multi-1:0]       kfail_q;
  logic [Multi*MEB-1:0]   err_q;
  logic [BW-1:0]          coef_q;
  logic [ChunkBits-1:0]   idx;
  logic [TimeoutBits-1:0] tmo;
  logic                   res_fail;
  logic [MEB-1:0]         res_cnt;
  logic [CW-1:0]          cs_coef_q;
  logic [ChunkBits-1:0]   cs_chunk_q;

  logic [CW-1:0]  cur_coef;
  logic [MEB-1:0] cur_err;
  logic           cur_fail;
  logic           cur_need;
  logic           last_chunk;
  logic           tmo_hit;
  logic           clear;
  logic           accept;

  assign clear      = i_RESET | i_stop_dec;
  assign accept     = (state == S_IDLE) & i_exe_cs;
  assign cur_err    = err_q[int'(idx)*MEB +: MEB];
  assign cur_fail   = kfail_q[idx];
  assign cur_need   = seq_end_q[idx];
  assign last_chunk = (idx == ChunkBits'(Multi-1));
  assign tmo_hit    = (tmo == TimeoutBits'(TimeoutCycles-1));

  // Gather the current chunk's coefficients, coefficient 0 in the MSBs
  always_comb begin
    cur_coef = '0;
    for (int k = 0; k < ELP; k++) begin
      cur_coef[(ELP-1-k)*GFD +: GFD] =
        coef_q[(ELP-1-k)*Multi*GFD + int'(idx)*GFD +: GFD];
    end
  end

  // State register; stop behaves exactly like reset
  always_ff @(posedge i_clk) begin
    if (clear) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (i_exe_cs) state_n = S_SELECT;
      end
      S_SELECT: begin
        if (cur_fail || !cur_need) state_n = S_REPORT;
        else                       state_n = S_START;
      end
      S_START: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (i_cs_done || tmo_hit) state_n = S_REPORT;
      end
      S_REPORT: begin
        if (last_chunk) state_n = S_DONE;
        else            state_n = S_SELECT;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Capture the whole bundle when it is accepted in Idle
  always_ff @(posedge i_clk) begin
    if (clear) begin
      seq_end_q <= '0;
      kfail_q   <= '0;
      err_q     <= '0;
      coef_q    <= '0;
    end else if (accept) begin
      seq_end_q <= i_kes_sequence_end;
      kfail_q   <= i_kes_fail;
      err_q     <= i_error_count;
      coef_q    <= i_ELP_coef;
    end
  end

  // Chunk index walks 0..Multi-1 once per bundle
  always_ff @(posedge i_clk) begin
    if (clear) begin
      idx <= '0;
    end else if (accept) begin
      idx <= '0;
    end else if (state == S_REPORT && !last_chunk) begin
      idx <= idx + ChunkBits'(1);
    end
  end

  // Engine operands, loaded only for chunks that go to the engine
  always_ff @(posedge i_clk) begin
    if (clear) begin
      cs_coef_q  <= '0;
      cs_chunk_q <= '0;
    end else if (state == S_SELECT && cur_need && !cur_fail) begin
      cs_coef_q  <= cur_coef;
      cs_chunk_q <= idx;
    end
  end

  // Wait watchdog, zeroed as the engine is started
  always_ff @(posedge i_clk) begin
    if (clear) begin
      tmo <= '0;
    end else if (state == S_START) begin
      tmo <= '0;
    end else if (state == S_WAIT && !i_cs_done && !tmo_hit) begin
      tmo <= tmo + TimeoutBits'(1);
    end
  end

  // Per-chunk verdict; done wins over a simultaneous timeout
  always_ff @(posedge i_clk) begin
    if (clear) begin
      res_fail <= 1'b0;
      res_cnt  <= '0;
    end else if (state == S_SELECT) begin
      res_fail <= cur_fail;
      res_cnt  <= '0;
    end else if (state == S_WAIT) begin
      if (i_cs_done) begin
        res_fail <= (i_root_count != cur_err);
        res_cnt  <= (i_root_count == cur_err) ? cur_err : '0;
      end else if (tmo_hit) begin
        res_fail <= 1'b1;
        res_cnt  <= '0;
      end
    end
  end

  assign o_cs_available        = (state == S_IDLE);
  assign o_cs_start            = (state == S_START);
  assign o_cs_coef             = cs_coef_q;
  assign o_cs_chunk_number     = cs_chunk_q;
  assign o_result_valid        = (state == S_REPORT);
  assign o_result_chunk_number = o_result_valid ? idx : '0;
  assign o_result_fail         = o_result_valid & res_fail;
  assign o_result_error_count  = o_result_valid ? res_cnt : '0;
  assign o_sequence_done       = (state == S_DONE);

endmodule
